// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_rr_arbiter
// Description : Two-requester round-robin arbiter and sequencer in front of a
//               single-port synchronous RAM. Commands are serialised onto the
//               RAM port; read data is routed back to the issuing requester
//               through a tag pipeline that tracks the RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  // requester 1
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // RAM port
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // One stage for the ram_addr output register (the RAM samples the address
  // one edge after acceptance) plus RD_LAT+1 stages matching the RAM's
  // sampling and read pipeline, so the tag lines up with ram_q.
  localparam int TAG_DEPTH = RD_LAT + 2;

  logic                  last_grant;
  logic                  accept;
  logic                  grant_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [TAG_DEPTH-1:0]  tag_vld;
  logic [TAG_DEPTH-1:0]  tag_id;

  // Round-robin grant: a lone valid wins; on a tie the requester that was not
  // granted last wins. Nothing is granted while reset is asserted.
  always_comb begin
    req0_ready = ~reset & req0_valid & (~req1_valid | last_grant);
    req1_ready = ~reset & req1_valid & (~req0_valid | ~last_grant);
    accept     = req0_ready | req1_ready;
    grant_id   = req1_ready;
    sel_we     = grant_id ? req1_we    : req0_we;
    sel_addr   = grant_id ? req1_addr  : req0_addr;
    sel_wdata  = grant_id ? req1_wdata : req0_wdata;
  end

  // Arbitration history: remember who was granted on every accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

  // RAM drive registers: load the granted command; write enable pulses once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else if (accept) begin
      ram_we   <= sel_we;
      ram_addr <= sel_addr;
      ram_data <= sel_wdata;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // Tag pipeline: tracks which requester owns each in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[TAG_DEPTH-2:0], accept & ~sel_we};
      tag_id  <= {tag_id[TAG_DEPTH-2:0], grant_id};
    end
  end

  // Response routing: the last tag stage selects which port sees the data.
  always_comb begin
    rsp0_valid = tag_vld[TAG_DEPTH-1] & ~tag_id[TAG_DEPTH-1];
    rsp1_valid = tag_vld[TAG_DEPTH-1] &  tag_id[TAG_DEPTH-1];
    rsp0_rdata = ram_q;
    rsp1_rdata = ram_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rr_arbiter
// Description : Self-checking bench for ram_rr_arbiter with a behavioural
//               single-port RAM, directed command queues and a response
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rr_arbiter;

  localparam int DW     = 16;
  localparam int AW     = 5;
  localparam int RD_LAT = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr  = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req0_ready, rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr  = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req1_ready, rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address sampled one edge after it is driven, word on
  // ram_q RD_LAT edges after sampling.
  logic [DW-1:0] mem   [2**AW];
  logic [DW-1:0] rpipe [RD_LAT+1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i <= RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_q = rpipe[RD_LAT];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } cmd_t;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  cmd_t          cq0[$];
  cmd_t          cq1[$];
  exp_t          sb[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  logic [15:0]   ghist = '0;
  logic [AW-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] e);
    return '{we: we, addr: a, wdata: d, exp: e};
  endfunction

  task automatic drive();
    req0_valid = (cq0.size() > 0);
    if (cq0.size() > 0) begin
      req0_we = cq0[0].we; req0_addr = cq0[0].addr; req0_wdata = cq0[0].wdata;
    end
    req1_valid = (cq1.size() > 0);
    if (cq1.size() > 0) begin
      req1_we = cq1[0].we; req1_addr = cq1[0].addr; req1_wdata = cq1[0].wdata;
    end
  endtask

  // One clock of stimulus: present commands, log the grant, check RAM drive.
  task automatic run_cycle();
    logic a0, a1, acc;
    cmd_t c;
    c = '0;
    @(negedge clk);
    drive();
    #2;
    a0  = req0_valid & req0_ready;
    a1  = req1_valid & req1_ready;
    acc = a0 | a1;
    if (!req0_valid) check("ready0_without_valid", req0_ready, 0);
    if (!req1_valid) check("ready1_without_valid", req1_ready, 0);
    if (req0_valid && req1_valid) check("single_accept", a0 & a1, 0);
    if (acc) begin
      c     = a0 ? cq0[0] : cq1[0];
      ghist = {ghist[14:0], a1 & ~a0};
      if (!c.we) sb.push_back('{id: a1 & ~a0, data: c.exp, cyc: cyc + 1 + RD_LAT + 1});
      if (a0) void'(cq0.pop_front());
      else    void'(cq1.pop_front());
    end
    @(posedge clk);
    #1;
    check("ram_we", ram_we, acc & c.we);
    if (acc) begin
      check("ram_addr", ram_addr, c.addr);
      check("ram_data", ram_data, c.wdata);
      last_addr = c.addr;
    end else begin
      check("ram_addr_hold", ram_addr, last_addr);
    end
    drive();
  endtask

  task automatic run_until_empty(input int maxc);
    for (int i = 0; i < maxc && (cq0.size() > 0 || cq1.size() > 0); i++) run_cycle();
    check("cmds_drained", cq0.size() + cq1.size(), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("responses_drained", sb.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    last_addr = '0;
  endtask

  // Response monitor: every presented response must match the oldest
  // expected read in id, data and arrival cycle.
  always @(negedge clk) begin
    if (!reset && (rsp0_valid || rsp1_valid)) begin
      if (rsp0_valid && rsp1_valid) begin
        check("rsp_exclusive", 1, 0);
      end else if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp0_valid=%0b rsp1_valid=%0b expected none (cycle %0d)",
                 rsp0_valid, rsp1_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp1_valid, mon_e.id);
        check("rsp_data", rsp1_valid ? rsp1_rdata : rsp0_rdata, mon_e.data);
        check("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 16'hA000 + 16'(i);

    // Reset state, including readys forced low while a valid is present.
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Write then read-back on requester 0.
    cq0.push_back(mk(1'b1, 5'd3, 16'hBEEF, 16'h0000));
    cq0.push_back(mk(1'b0, 5'd3, 16'h0000, 16'hBEEF));
    run_until_empty(10);
    drain();

    // Both requesters continuously reading: grants alternate starting at 0.
    apply_reset();
    ghist = '0;
    for (int i = 0; i < 4; i++) begin
      cq0.push_back(mk(1'b0, 5'd1, 16'h0000, 16'hA001));
      cq1.push_back(mk(1'b0, 5'd2, 16'h0000, 16'hA002));
    end
    run_until_empty(20);
    check("alternate_grants", ghist[7:0], 8'b01010101);
    drain();

    // Requester 1 alone four times, then requester 0 joins and wins the tie.
    apply_reset();
    ghist = '0;
    cq1.push_back(mk(1'b0, 5'd4,  16'h0000, 16'hA004));
    cq1.push_back(mk(1'b0, 5'd5,  16'h0000, 16'hA005));
    cq1.push_back(mk(1'b0, 5'd6,  16'h0000, 16'hA006));
    cq1.push_back(mk(1'b0, 5'd8,  16'h0000, 16'hA008));
    repeat (4) run_cycle();
    cq0.push_back(mk(1'b0, 5'd9,  16'h0000, 16'hA009));
    cq1.push_back(mk(1'b0, 5'd10, 16'h0000, 16'hA00A));
    run_until_empty(10);
    check("solo_then_tie_grants", ghist[5:0], 6'b111101);
    drain();

    // Write from requester 0 immediately followed by read from requester 1.
    ghist = '0;
    cq0.push_back(mk(1'b1, 5'd7, 16'h1234, 16'h0000));
    cq1.push_back(mk(1'b0, 5'd7, 16'h0000, 16'h1234));
    run_until_empty(10);
    check("write_read_grants", ghist[1:0], 2'b01);
    drain();

    // Reset while reads are in flight: the second response is dropped.
    apply_reset();
    cq0.push_back(mk(1'b0, 5'd1, 16'h0000, 16'hA001));
    cq1.push_back(mk(1'b0, 5'd2, 16'h0000, 16'hA002));
    run_cycle();
    run_cycle();
    repeat (3) @(negedge clk);
    #2;
    req0_valid = 1'b1;
    req0_we    = 1'b0;
    req0_addr  = 5'd1;
    reset      = 1'b1;
    #1;
    check("async_rst_rsp0", rsp0_valid, 0);
    check("async_rst_rsp1", rsp1_valid, 0);
    check("async_rst_ready0", req0_ready, 0);
    check("async_rst_ram_we", ram_we, 0);
    sb.delete();
    @(negedge clk);
    req0_valid = 1'b0;
    reset      = 1'b0;
    last_addr  = '0;
    repeat (6) @(negedge clk);
    ghist = '0;
    cq0.push_back(mk(1'b0, 5'd5, 16'h0000, 16'hA005));
    cq1.push_back(mk(1'b0, 5'd6, 16'h0000, 16'hA006));
    run_until_empty(10);
    check("post_reset_tie_grants", ghist[1:0], 2'b01);
    drain();

    // Idle: no readys, no write strobe, address holds, no responses.
    repeat (10) run_cycle();
    check("idle_addr", ram_addr, 5'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
